// File: rtl/tcp_tx_pkg.sv
// Shared types and constants for the TCP transmit cell demultiplexer.
// The optional statistics block is enabled with the TCPKT_DMX_STAT_EN macro.
package tcp_tx_pkg;

    // Input framing FSM: waiting for a start-of-cell, or inside a cell body
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } tx_fsm_e;

    // Default geometry. Module parameters may override these per instance.
    localparam int CHN_NUM_DEF = 4;
    localparam int CHN_AWID    = $clog2(CHN_NUM_DEF);
    localparam int PDWID_DEF   = 128;

    // One stored beat: start-of-cell flag plus payload (default width)
    typedef struct packed {
        logic                 soc;
        logic [PDWID_DEF-1:0] dat;
    } tcp_tx_beat_t;

    // 16-bit saturating increment used by the status counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tcp_tx_cell_fifo.sv
// First-word-fall-through synchronous FIFO for one output channel.
// A write in cycle N is visible on rd_dat_o in cycle N+1. Simultaneous
// read and write are legal when full or empty; free_o reports DEPTH-count.
module tcp_tx_cell_fifo
    import tcp_tx_pkg::*;
#(
    parameter int DWID  = 129,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [DWID-1:0]            wr_dat_i,
    input  logic                       rd_en_i,
    output logic [DWID-1:0]            rd_dat_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWID-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = rd_en_i && !empty_o;
    // A write into a full FIFO is only taken when a read frees a slot this cycle
    assign do_push = wr_en_i && (!full || do_pop);

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign free_o   = CW'(DEPTH) - cnt_q;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array, no reset so it maps onto plain memory
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tcp_tx_tcpkt_dmx.sv
// Transmit cell demultiplexer: steers whole fixed-length cells from one
// interleaved input stream into per-channel FWFT FIFOs chosen by the flow
// key. Each channel drains under its own ready.
// Optional statistics on dbg_sig are built when TCPKT_DMX_STAT_EN is defined;
// otherwise dbg_sig is constant zero.
module tcp_tx_tcpkt_dmx
    import tcp_tx_pkg::*;
#(
    parameter int PDWID      = 128,
    parameter int PDSZ       = 4,
    parameter int CHN_NUM    = 4,
    parameter int KEY_WID    = 16,
    parameter int FIFO_CELLS = 4,
    parameter int DBG_WID    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [PDWID-1:0]         in_dat,
    input  logic                     in_soc,
    input  logic [KEY_WID-1:0]       in_key,
    output logic                     in_rdy,
    output logic [CHN_NUM-1:0]       out_vld,
    output logic [CHN_NUM*PDWID-1:0] out_dat,
    output logic [CHN_NUM-1:0]       out_soc,
    input  logic [CHN_NUM-1:0]       out_rdy,
    output logic [DBG_WID-1:0]       dbg_sig
);

    localparam int SEL_W = $clog2(CHN_NUM);
    localparam int BCW   = $clog2(PDSZ);
    localparam int DEPTH = FIFO_CELLS * PDSZ;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(PDSZ - 1);

    tx_fsm_e          state_q, state_d;
    logic [SEL_W-1:0] lock_chn_q, lock_chn_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0] key_chn;
    logic [SEL_W-1:0] wr_chn;
    logic [CW-1:0]    free_w [CHN_NUM];
    logic             acc;
    logic             soc_acc;
    logic             body_acc;
    logic [PDWID:0]   wr_dat;
    logic             key_unused;

    // Only the low key bits select a channel; the rest are intentionally ignored
    assign key_chn    = in_key[SEL_W-1:0];
    assign key_unused = ^in_key[KEY_WID-1:SEL_W];

    // Admission: a new cell needs a full cell of space in its channel; body
    // beats were reserved at soc; orphan beats are always swallowed.
    always_comb begin
        in_rdy = 1'b0;
        if (rst) begin
            if (state_q == ST_BODY) begin
                in_rdy = 1'b1;
            end else if (in_soc) begin
                in_rdy = (free_w[key_chn] >= CW'(PDSZ));
            end else begin
                in_rdy = 1'b1;
            end
        end
    end

    assign acc      = in_vld && in_rdy;
    assign soc_acc  = acc && (state_q == ST_IDLE) && in_soc;
    assign body_acc = acc && (state_q == ST_BODY);
    assign wr_chn   = (state_q == ST_IDLE) ? key_chn : lock_chn_q;
    // A soc seen inside a body is stored as a plain beat
    assign wr_dat   = {soc_acc, in_dat};

    // Framing FSM next-state
    always_comb begin
        state_d    = state_q;
        lock_chn_d = lock_chn_q;
        beat_cnt_d = beat_cnt_q;
        if (soc_acc) begin
            state_d    = ST_BODY;
            lock_chn_d = key_chn;
            beat_cnt_d = BCW'(1);
        end else if (body_acc) begin
            if (beat_cnt_q == LAST_BEAT) begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    // Framing FSM registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            lock_chn_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_chn_q <= lock_chn_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHN_NUM; gi++) begin : g_chn
            logic           wr_en;
            logic [PDWID:0] rd_dat;
            logic           empty;

            assign wr_en = (soc_acc || body_acc) && (wr_chn == SEL_W'(gi));

            tcp_tx_cell_fifo #(
                .DWID  (PDWID + 1),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .wr_en_i  (wr_en),
                .wr_dat_i (wr_dat),
                .rd_en_i  (out_rdy[gi]),
                .rd_dat_o (rd_dat),
                .empty_o  (empty),
                .free_o   (free_w[gi])
            );

            // Outputs are zeroed while empty so nothing stale leaks out
            assign out_vld[gi]                 = !empty;
            assign out_soc[gi]                 = !empty && rd_dat[PDWID];
            assign out_dat[gi*PDWID +: PDWID]  = empty ? '0 : rd_dat[PDWID-1:0];
        end
    endgenerate

`ifdef TCPKT_DMX_STAT_EN
    logic [15:0] cell_cnt_q;
    logic [15:0] err_cnt_q;
    logic        err_ev;

    // Orphan beats in IDLE and stray soc inside a body are both errors
    assign err_ev = acc && (((state_q == ST_IDLE) && !in_soc) ||
                            ((state_q == ST_BODY) && in_soc));

    // Saturating admitted-cell and error counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cell_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (soc_acc) cell_cnt_q <= sat_inc16(cell_cnt_q);
            if (err_ev)  err_cnt_q  <= sat_inc16(err_cnt_q);
        end
    end

    assign dbg_sig = DBG_WID'({err_cnt_q, cell_cnt_q});
`else
    assign dbg_sig = '0;
`endif

endmodule
